// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the FSM state encoding and the latency constant used by users of the divider.
package div_pkg;

  localparam int DIV_WIDTH     = 16;
  localparam int ITER_W        = $clog2(DIV_WIDTH);
  localparam int FIXED_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit and try to subtract.
// The incoming remainder is always below the divisor, so it fits WIDTH bits.
import div_pkg::*;

module div_step #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic             d_bit,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // trial >= m exactly when the subtraction does not borrow into the top bit
  always_comb begin
    trial = {p_in, d_bit};
    diff  = trial - {1'b0, m};
    q_bit = ~diff[WIDTH];
    p_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIV_EARLY_EN to finish early when |dividend| < |divisor|.
import div_pkg::*;

module seq_divider #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               error
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state, state_nx;

  logic [WIDTH-1:0]   dd_r, dv_r;
  logic [WIDTH-1:0]   a_r, m_r, p_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               qneg_r, rneg_r;

  logic [WIDTH-1:0]   p_nx;
  logic               q_bit;
  logic [WIDTH-1:0]   q_mag;
  logic [2*WIDTH-1:0] q_ext, q_fix;
  logic [WIDTH-1:0]   r_fix, r_early;

  logic accept, zero_div, last, early;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p_r),
    .d_bit (a_r[WIDTH-1]),
    .m     (m_r),
    .p_out (p_nx),
    .q_bit (q_bit)
  );

  // Final sign correction applied as results are registered
  always_comb begin
    q_mag   = {a_r[WIDTH-2:0], q_bit};
    q_ext   = {{WIDTH{1'b0}}, q_mag};
    q_fix   = qneg_r ? -q_ext : q_ext;
    r_fix   = rneg_r ? -p_nx : p_nx;
    r_early = rneg_r ? -a_r : a_r;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state; FIX accepts a new start so requests can run back to back
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    zero_div = 1'b0;
    last     = 1'b0;
    early    = 1'b0;
    unique case (state)
      IDLE, FIX: begin
        if (state == FIX) state_nx = IDLE;
        if (start) begin
          accept = 1'b1;
          if (divisor == '0) begin
            zero_div = 1'b1;
            state_nx = FIX;
          end else begin
            state_nx = PREP;
          end
        end
      end
      PREP: state_nx = RUN;
      RUN: begin
`ifdef SEQ_DIV_EARLY_EN
        early = (cnt_r == '0) && (a_r < m_r);
`endif
        last = (cnt_r == CNT_W'(WIDTH-1));
        if (early || last) state_nx = FIX;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dd_r      <= '0;
      dv_r      <= '0;
      a_r       <= '0;
      m_r       <= '0;
      p_r       <= '0;
      cnt_r     <= '0;
      qneg_r    <= 1'b0;
      rneg_r    <= 1'b0;
    end else begin
      busy <= (state_nx == PREP) || (state_nx == RUN);
      done <= (state_nx == FIX);
      if (accept) begin
        dd_r <= dividend;
        dv_r <= divisor;
      end
      if (zero_div) begin
        quotient  <= '0;
        remainder <= dividend;
        error     <= 1'b1;
      end
      if (state == PREP) begin
        qneg_r <= dd_r[WIDTH-1] ^ dv_r[WIDTH-1];
        rneg_r <= dd_r[WIDTH-1];
        a_r    <= dd_r[WIDTH-1] ? -dd_r : dd_r;
        m_r    <= dv_r[WIDTH-1] ? -dv_r : dv_r;
        p_r    <= '0;
        cnt_r  <= '0;
      end
      if (state == RUN) begin
        if (early) begin
          quotient  <= '0;
          remainder <= r_early;
          error     <= 1'b0;
        end else begin
          p_r   <= p_nx;
          a_r   <= q_mag;
          cnt_r <= cnt_r + 1'b1;
          if (last) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            error     <= 1'b0;
          end
        end
      end
    end
  end

endmodule
